// File: rtl/clkdiv_ratio_ctrl.sv
// Run-time controller for the programmable integer clock divider: owns the ratio/period counter,
// applies ratio changes only at period boundaries. Optional 50% duty for odd ratios: CLKDIV_DUTY50_EN.
//
// state | meaning
// IDLE  | counter held at 0, divided clock low
// RUN   | counting with the active ratio
// PEND  | counting, new ratio waits for the period end
// STOP  | counting, finishing the period before IDLE
module clkdiv_ratio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [WIDTH-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic [WIDTH-1:0] o_active_div,
  output logic             o_div_clk,
  output logic             o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;

  logic             period_end;
  logic [WIDTH-1:0] count_next;
  logic             accept;
  logic             req_bad;
  logic             div_pos;

  assign period_end = (state_q != ST_IDLE) && (count_q == active_div_q - WIDTH'(1));
  assign count_next = period_end ? '0 : count_q + WIDTH'(1);
  assign o_cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept      = i_cfg_valid && o_cfg_ready;
  assign req_bad     = i_cfg_div < WIDTH'(2);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    active_div_d = active_div_q;
    pending_d    = pending_q;
    cfg_err_d    = accept && req_bad;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (accept && !req_bad) active_div_d = i_cfg_div;
        if (i_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        count_d = count_next;
        if (accept && !req_bad) begin
          pending_d = i_cfg_div;
          state_d   = ST_PEND;
        end else if (!i_en) begin
          state_d = ST_STOP;
        end
      end
      ST_PEND: begin
        count_d = count_next;
        // a disable during PEND still commits the new ratio on the way to IDLE
        if (period_end) begin
          active_div_d = pending_q;
          state_d      = i_en ? ST_RUN : ST_IDLE;
        end
      end
      ST_STOP: begin
        count_d = count_next;
        if (i_en) state_d = ST_RUN;
        else if (period_end) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      active_div_q <= DIV_RST;
      pending_q    <= DIV_RST;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      active_div_q <= active_div_d;
      pending_q    <= pending_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign div_pos = (state_q != ST_IDLE) && (count_q < (active_div_q >> 1));

`ifdef CLKDIV_DUTY50_EN
  logic div_neg_q, div_neg_d;

  // half-cycle delayed copy stretches odd ratios by half a clk period
  assign div_neg_d = (state_q != ST_IDLE) && div_pos;

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) div_neg_q <= 1'b0;
    else         div_neg_q <= div_neg_d;
  end

  assign o_div_clk = div_pos | (active_div_q[0] & div_neg_q);
`else
  assign o_div_clk = div_pos;
`endif

  assign o_cfg_err    = cfg_err_q;
  assign o_count      = count_q;
  assign o_count_end  = period_end;
  assign o_active_div = active_div_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Directed bench for clkdiv_ratio_ctrl; outputs sampled on the falling edge, inputs driven there too.
// Define CLKDIV_DUTY50_EN to also measure the odd-ratio duty cycle.
module tb_clkdiv_ratio_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       i_en;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_div;
  logic       o_cfg_ready;
  logic       o_cfg_err;
  logic [7:0] o_count;
  logic       o_count_end;
  logic [7:0] o_active_div;
  logic       o_div_clk;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  clkdiv_ratio_ctrl #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_en         (i_en),
    .i_cfg_valid  (i_cfg_valid),
    .i_cfg_div    (i_cfg_div),
    .o_cfg_ready  (o_cfg_ready),
    .o_cfg_err    (o_cfg_err),
    .o_count      (o_count),
    .o_count_end  (o_count_end),
    .o_active_div (o_active_div),
    .o_div_clk    (o_div_clk),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // count, divided clock, period-end flag, active ratio, busy
  task automatic chk_st(input string tag, input int cnt, input int dclk, input int cend,
                        input int act, input int busy);
    chk({tag, ".count"},  {24'd0, o_count},      cnt);
    chk({tag, ".divclk"}, {31'd0, o_div_clk},    dclk);
    chk({tag, ".end"},    {31'd0, o_count_end},  cend);
    chk({tag, ".active"}, {24'd0, o_active_div}, act);
    chk({tag, ".busy"},   {31'd0, o_busy},       busy);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

`ifdef CLKDIV_DUTY50_EN
  task automatic measure(input int n, input int exp_halves);
    int highs;
    highs = 0;
    repeat (2 * n) begin
      @(posedge clk or negedge clk);
      #1;
      highs += int'(o_div_clk);
    end
    chk($sformatf("duty.n%0d", n), highs, exp_halves);
  endtask

  task automatic set_ratio(input int n, input int old_n);
    @(negedge clk);
    i_cfg_valid = 1'b1;
    i_cfg_div   = 8'(n);
    @(negedge clk);
    i_cfg_valid = 1'b0;
    repeat (old_n + 2) @(negedge clk);
  endtask
`endif

  initial begin
    resetn      = 1'b0;
    i_en        = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_div   = 8'd0;

    // reset values
    repeat (10) tick();
    chk_st("rst", 0, 0, 0, 3, 0);
    chk("rst.ready", {31'd0, o_cfg_ready}, 1);
    chk("rst.err",   {31'd0, o_cfg_err},   0);

    // enable, N=3: count 0,1,2 with clock 1,0,0
    resetn = 1'b1;
    i_en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_st($sformatf("run3.%0d", i), i % 3, (i % 3 == 0) ? 1 : 0, (i % 3 == 2) ? 1 : 0, 3, 1);
    end

    // illegal requests N=1 then N=0
    tick();
    chk_st("ill.c0", 0, 1, 0, 3, 1);
    i_cfg_valid = 1'b1; i_cfg_div = 8'd1;
    tick();
    chk("ill1.err", {31'd0, o_cfg_err}, 1);
    chk_st("ill1", 1, 0, 0, 3, 1);
    chk("ill1.ready", {31'd0, o_cfg_ready}, 1);
    i_cfg_valid = 1'b0;
    tick();
    chk("ill1.errclr", {31'd0, o_cfg_err}, 0);
    chk_st("ill1b", 2, 0, 1, 3, 1);
    i_cfg_valid = 1'b1; i_cfg_div = 8'd0;
    tick();
    chk("ill0.err", {31'd0, o_cfg_err}, 1);
    chk_st("ill0", 0, 1, 0, 3, 1);
    i_cfg_valid = 1'b0;
    tick();
    chk("ill0.errclr", {31'd0, o_cfg_err}, 0);
    chk_st("ill0b", 1, 0, 0, 3, 1);
    tick();
    chk_st("ill0c", 2, 0, 1, 3, 1);

    // change 3 -> 5 requested at count 0
    tick();
    chk_st("ch5.c0", 0, 1, 0, 3, 1);
    i_cfg_valid = 1'b1; i_cfg_div = 8'd5;
    tick();
    chk("ch5.ready1", {31'd0, o_cfg_ready}, 0);
    chk_st("ch5.p1", 1, 0, 0, 3, 1);
    i_cfg_valid = 1'b0;
    tick();
    chk("ch5.ready2", {31'd0, o_cfg_ready}, 0);
    chk_st("ch5.p2", 2, 0, 1, 3, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_st($sformatf("run5.%0d", i), i, (i < 2) ? 1 : 0, (i == 4) ? 1 : 0, 5, 1);
      chk($sformatf("run5.ready%0d", i), {31'd0, o_cfg_ready}, 1);
    end

    // change 5 -> 4
    tick();
    chk_st("ch4.c0", 0, 1, 0, 5, 1);
    i_cfg_valid = 1'b1; i_cfg_div = 8'd4;
    tick();
    i_cfg_valid = 1'b0;
    chk_st("ch4.p1", 1, 1, 0, 5, 1);
    repeat (3) tick();
    chk_st("ch4.p4", 4, 0, 1, 5, 1);
    tick();
    chk_st("ch4.c0b", 0, 1, 0, 4, 1);

    // disable at count 0 with N=4: finish the period, then IDLE
    i_en = 1'b0;
    tick();
    chk_st("stop.1", 1, 1, 0, 4, 1);
    chk("stop.ready", {31'd0, o_cfg_ready}, 0);
    tick();
    chk_st("stop.2", 2, 0, 0, 4, 1);
    tick();
    chk_st("stop.3", 3, 0, 1, 4, 1);
    tick();
    chk_st("idle.0", 0, 0, 0, 4, 0);
    chk("idle.ready", {31'd0, o_cfg_ready}, 1);
    tick();
    chk_st("idle.1", 0, 0, 0, 4, 0);

    // accept N=3 in IDLE on the same cycle as enable
    i_en = 1'b1; i_cfg_valid = 1'b1; i_cfg_div = 8'd3;
    tick();
    i_cfg_valid = 1'b0;
    chk_st("sim.0", 0, 1, 0, 3, 1);
    tick();
    chk_st("sim.1", 1, 0, 0, 3, 1);
    tick();
    chk_st("sim.2", 2, 0, 1, 3, 1);
    tick();
    chk_st("sim.3", 0, 1, 0, 3, 1);

    // request 6, then disable while pending
    i_cfg_valid = 1'b1; i_cfg_div = 8'd6;
    tick();
    i_cfg_valid = 1'b0;
    i_en        = 1'b0;
    chk_st("pdis.1", 1, 0, 0, 3, 1);
    tick();
    chk_st("pdis.2", 2, 0, 1, 3, 1);
    tick();
    chk_st("pdis.idle", 0, 0, 0, 6, 0);

    // N=6: stop then re-enable, counting continues
    i_en = 1'b1;
    tick();
    chk_st("re.0", 0, 1, 0, 6, 1);
    tick();
    chk_st("re.1", 1, 1, 0, 6, 1);
    i_en = 1'b0;
    tick();
    chk_st("re.stop2", 2, 1, 0, 6, 1);
    chk("re.stopready", {31'd0, o_cfg_ready}, 0);
    i_en = 1'b1;
    tick();
    chk_st("re.3", 3, 0, 0, 6, 1);
    chk("re.ready", {31'd0, o_cfg_ready}, 1);
    tick();
    tick();
    chk_st("re.5", 5, 0, 1, 6, 1);
    tick();
    chk_st("re.w0", 0, 1, 0, 6, 1);

    // reset with a ratio pending discards it
    i_cfg_valid = 1'b1; i_cfg_div = 8'd7;
    tick();
    i_cfg_valid = 1'b0;
    chk("mrst.pend", {31'd0, o_cfg_ready}, 0);
    resetn = 1'b0;
    #1;
    chk_st("mrst", 0, 0, 0, 3, 0);
    chk("mrst.ready", {31'd0, o_cfg_ready}, 1);
    tick();
    resetn = 1'b1;
    tick();
    chk_st("mrst.r0", 0, 1, 0, 3, 1);
    repeat (3) tick();
    chk_st("mrst.r3", 0, 1, 0, 3, 1);

`ifdef CLKDIV_DUTY50_EN
    measure(3, 3);
    set_ratio(5, 3);
    measure(5, 5);
    set_ratio(4, 5);
    measure(4, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_ratio_ctrl.md
# clkdiv_ratio_ctrl

Run-time controller for the programmable integer clock divider. It owns the divide ratio and the period counter, and accepts ratio changes over a valid/ready handshake. New ratios are applied only at a period boundary, so the divided clock never produces a runt pulse. It also sequences enable and disable cleanly: it always finishes the current period before stopping. It generalises the fixed divide-by-3 counter into a shared, reconfigurable divider used by downstream slow-clock consumers.

## Interface
- `WIDTH`, 8, width of the ratio and counter.
- `DEFAULT_DIV`, 3, ratio loaded at reset; must be ≥2.
- `clk` input 1: system clock; all state is on the rising edge, except the optional negedge flop (see Configuration).
- `resetn` input 1: asynchronous, active-low reset.
- `i_en` input 1: run request. Level sensitive.
- `i_cfg_valid` input 1: ratio change request.
- `i_cfg_div` input WIDTH: requested ratio N.
- `o_cfg_ready` output 1: controller can accept a request.
- `o_cfg_err` output 1: one-cycle pulse when an accepted request is rejected because N<2.
- `o_count` output WIDTH: period counter, 0..N-1.
- `o_count_end` output 1: high while `o_count == active_div-1` and state is RUN, PEND or STOP.
- `o_active_div` output WIDTH: ratio currently in effect.
- `o_div_clk` output 1: divided clock.
- `o_busy` output 1: state ≠ IDLE.

## Operation
- **States:**
  - IDLE: counter held at 0, `o_div_clk`=0.
  - RUN: counting.
  - PEND: counting, with a new ratio waiting.
  - STOP: counting, finishing the current period before IDLE.
- **Counter:** in any non-IDLE state, `count` goes 0→active_div-1, then wraps to 0. Width is WIDTH; no overflow is possible because count < active_div ≤ 2^WIDTH-1.
- **Clock shape:** `o_div_clk` = 1 when count < floor(active_div/2), else 0. Example: N=3 gives high 1 cycle, low 2. N=4 gives 2/2.
- **Handshake:**
  - A request is accepted on a cycle where `i_cfg_valid & o_cfg_ready` are both high.
  - `o_cfg_ready` = 1 in IDLE and RUN; 0 in PEND and STOP.
  - When ready=0, the requester holds valid and data stable.
- **Rejection:** if an accepted request has `i_cfg_div` < 2, `o_cfg_err` pulses the next cycle. No state change; `active_div` is unchanged.
- **Accept in IDLE:** `active_div` ← N on the next edge.
- **Accept in RUN:** `pending` ← N and the state goes to PEND.
- **At a period end (count == active_div-1):**
  - PEND → RUN, with `active_div` ← pending and count ← 0.
  - STOP → IDLE, with count ← 0.
- **IDLE + `i_en`=1 → RUN:** count starts at 0, so `o_div_clk` rises on the first RUN cycle.
- **`i_en` falls in RUN → STOP.**
- **`i_en` falls in PEND:**
  - Stay in PEND until the period end.
  - At the period end, apply `pending` and go to IDLE.
- **`i_en` rises in STOP → RUN:** the stop is cancelled and counting continues without a restart.
- **Simultaneous events:**
  - An accept in RUN on the period-end cycle still goes to PEND. The new ratio takes effect at the next period end.
  - An accept in IDLE on the same cycle as `i_en` rises applies N, and RUN starts at count 0 with the new N.

## Timing
- **Reset values:**
  - `o_count`=0, `o_count_end`=0, `o_div_clk`=0, `o_busy`=0, `o_cfg_err`=0.
  - `o_cfg_ready`=1.
  - `o_active_div`=DEFAULT_DIV.
  - State IDLE, `pending`=DEFAULT_DIV.
- **Registered vs derived outputs:** all outputs are registered or decoded only from registers; there is no combinational input→output path.
- **Enable latency:** `i_en` sampled high at edge k gives RUN, count=0 and `o_div_clk`=1 after edge k.
- **Ratio change latency:** the new ratio is in effect from the cycle after the first period end following acceptance. This is at most active_div+1 cycles.
- **Mid-operation reset:** assertion of `resetn` immediately forces the reset values. A pending ratio is discarded.

## Configuration
- **Macro:** `CLKDIV_DUTY50_EN`.
- **When defined:**
  - A falling-edge flop samples the posedge `o_div_clk` term.
  - For odd `active_div`, `o_div_clk` = posedge term OR negedge term. N=3 therefore gives 1.5 cycles high and 1.5 low.
  - Even ratios are unchanged.
  - The negedge flop resets to 0 and is cleared in IDLE.
- **When undefined:** no negedge logic; shape as in Operation.

## Test plan
- **Reset then enable:** `resetn` low for 10 cycles, then `i_en`=1.
  - `o_active_div`=3.
  - `o_count` sequence 0,1,2,0…
  - `o_div_clk` 1,0,0 repeating.
  - `o_count_end` on count 2.
- **Change in RUN:** in RUN with N=3, send N=5 at count 0.
  - `o_cfg_ready`=0 until the period end.
  - The next period is 0..4, with `o_div_clk` high for 2 cycles.
  - `o_cfg_ready` returns to 1.
- **Illegal request:** send N=1, then N=0.
  - `o_cfg_err` pulses for 1 cycle each.
  - `o_active_div` stays 3 and counting is undisturbed.
- **Disable mid-period:** drop `i_en` at count 0, N=4.
  - `o_busy` stays 1 through count 3.
  - IDLE follows, with `o_count`=0, `o_div_clk`=0 and no runt pulse.
- **Disable with pending, then re-enable:**
  - Drop `i_en` while in PEND (N 3→6): at the period end the state goes to IDLE with `o_active_div`=6.
  - Raise `i_en` in STOP: counting continues without restarting from 0.
- **With `CLKDIV_DUTY50_EN` defined, N=3 and N=5:**
  - `o_div_clk` high 1.5 and 2.5 cycles respectively, measured on time.
  - N=4 remains 2/2.
